// File: rtl/conv_window_addr_gen.sv
`timescale 1ns/1ps
// conv_window_addr_gen
//   Scans every valid KxK window of an IMG_H x IMG_W image in row-major order.
//   For each tap of each window it issues an image address and a filter address
//   over a valid/ready handshake. A start/done pair hooks it to the top controller.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for start, all outputs 0
//   ST_RUN  | addr_valid high, tap advances on addr_valid & addr_ready
//   ST_DONE | one-cycle done pulse, counters back at 0
//
// Ports
//   clk, rst         single clock, synchronous active-high reset
//   start            begins a scan (sampled in ST_IDLE only)
//   busy, done       status toward the top controller
//   addr_valid/ready tap handshake
//   img_addr         (out_row+i)*IMG_W + (out_col+j)
//   flt_addr         i*K + j
//   win_last         last tap of the current window
//   out_row/out_col  output-pixel position of the current window
module conv_window_addr_gen #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 addr_valid,
  input  logic                 addr_ready,
  output logic [ADDR_W-1:0]    img_addr,
  output logic [2*CNT_W-1:0]   flt_addr,
  output logic                 win_last,
  output logic [CNT_W-1:0]     out_row,
  output logic [CNT_W-1:0]     out_col
);

  localparam int FLT_W = 2 * CNT_W;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - K);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - K);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] r_q, r_d, c_q, c_d, i_q, i_d, j_q, j_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] img_q, img_d;
  logic [FLT_W-1:0]  flt_q, flt_d;
  logic              wl_q, wl_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic              run_d;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    i_d     = i_q;
    j_d     = j_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          r_d     = '0;
          c_d     = '0;
          i_d     = '0;
          j_d     = '0;
        end
      end
      ST_RUN: begin
        // addr_valid is always high here, so ready alone marks a handshake.
        if (addr_ready) begin
          if (j_q != LAST_TAP) begin
            j_d = j_q + 1'b1;
          end else begin
            j_d = '0;
            if (i_q != LAST_TAP) begin
              i_d = i_q + 1'b1;
            end else begin
              i_d = '0;
              if (c_q != LAST_COL) begin
                c_d = c_q + 1'b1;
              end else begin
                c_d = '0;
                if (r_q != LAST_ROW) begin
                  r_d = r_q + 1'b1;
                end else begin
                  r_d     = '0;
                  state_d = ST_DONE;
                end
              end
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are built from next-state values so they land in registers and
  // stay bit-stable under backpressure (counters simply do not move).
  always_comb begin
    run_d   = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    valid_d = run_d;
    img_d   = '0;
    flt_d   = '0;
    wl_d    = 1'b0;
    row_d   = '0;
    col_d   = '0;
    if (run_d) begin
      img_d = ADDR_W'((32'(r_d) + 32'(i_d)) * 32'(IMG_W) + 32'(c_d) + 32'(j_d));
      flt_d = FLT_W'(32'(i_d) * 32'(K) + 32'(j_d));
      wl_d  = (i_d == LAST_TAP) && (j_d == LAST_TAP);
      row_d = r_d;
      col_d = c_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      img_q   <= '0;
      flt_q   <= '0;
      wl_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      i_q     <= i_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      img_q   <= img_d;
      flt_q   <= flt_d;
      wl_q    <= wl_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign addr_valid = valid_q;
  assign img_addr   = img_q;
  assign flt_addr   = flt_q;
  assign win_last   = wl_q;
  assign out_row    = row_q;
  assign out_col    = col_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
`timescale 1ns/1ps
module tb_conv_window_addr_gen;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int K     = 3;
  localparam int NTAPS = (IMG_H - K + 1) * (IMG_W - K + 1) * K * K;

  logic clk, rst, start, ready;
  logic       busy, done, valid, wl;
  logic [5:0] img;
  logic [7:0] flt;
  logic [3:0] row, col;

  logic       busy1, done1, valid1, wl1;
  logic [5:0] img1;
  logic [7:0] flt1;
  logic [3:0] row1, col1;

  int n_chk  = 0;
  int n_fail = 0;

  conv_window_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(6), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .addr_valid(valid), .addr_ready(ready), .img_addr(img), .flt_addr(flt),
    .win_last(wl), .out_row(row), .out_col(col));

  conv_window_addr_gen #(.IMG_W(8), .IMG_H(8), .K(1), .ADDR_W(6), .CNT_W(4)) dut_k1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .addr_valid(valid1), .addr_ready(ready), .img_addr(img1), .flt_addr(flt1),
    .win_last(wl1), .out_row(row1), .out_col(col1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] pack(input logic b, input logic d, input logic v,
                                       input logic [5:0] ia, input logic [7:0] fa,
                                       input logic w, input logic [3:0] r, input logic [3:0] c);
    return {b, d, v, ia, fa, w, r, c};
  endfunction

  // Reference tap list: plain nested loops over window position then tap.
  int e_img[$], e_flt[$], e_row[$], e_col[$];
  bit e_wl[$];
  initial begin
    for (int r = 0; r <= IMG_H - K; r++)
      for (int c = 0; c <= IMG_W - K; c++)
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) begin
            e_img.push_back((r + i) * IMG_W + c + j);
            e_flt.push_back(i * K + j);
            e_row.push_back(r);
            e_col.push_back(c);
            e_wl.push_back(i == K - 1 && j == K - 1);
          end
  end

  // Protocol-level model: phase 0 idle, 1 scanning (tap idx), 2 done cycle.
  int ph = 0, idx = 0, hs_cnt = 0, done_cnt = 0;
  bit armed = 0, stall_prev = 0;
  logic [25:0] prev_v, act_v, exp_v;

  always @(negedge clk) begin
    act_v = pack(busy, done, valid, img, flt, wl, row, col);
    if (armed) begin
      if (ph == 1)
        exp_v = pack(1'b1, 1'b0, 1'b1, 6'(e_img[idx]), 8'(e_flt[idx]), e_wl[idx],
                     4'(e_row[idx]), 4'(e_col[idx]));
      else if (ph == 2)
        exp_v = pack(1'b1, 1'b1, 1'b0, 6'd0, 8'd0, 1'b0, 4'd0, 4'd0);
      else
        exp_v = '0;
      check("cycle_outputs", 32'(act_v), 32'(exp_v));
      if (stall_prev) check("stall_hold", 32'(act_v), 32'(prev_v));
      if (done) done_cnt++;
    end
    stall_prev = 0;
    if (rst) begin
      armed = 1; ph = 0; idx = 0;
    end else if (armed) begin
      case (ph)
        0: if (start) begin ph = 1; idx = 0; end
        1: begin
          if (ready) begin
            hs_cnt++;
            if (idx == NTAPS - 1) ph = 2;
            else idx++;
          end else begin
            stall_prev = 1;
          end
        end
        default: ph = 0;
      endcase
    end
    prev_v = act_v;
  end

  // K=1 build: tap n is simply pixel n, and every tap closes a window.
  int k1_idx = 0;
  always @(negedge clk) begin
    if (armed) begin
      if (valid1)
        check("k1_tap", 32'({wl1, img1, flt1, row1, col1}),
              32'({1'b1, 6'(k1_idx), 8'd0, 4'(k1_idx / 8), 4'(k1_idx % 8)}));
      if (done1) begin
        check("k1_tap_count", 32'(k1_idx), 32'd64);
        k1_idx = 0;
      end
    end
    if (rst) k1_idx = 0;
    else if (valid1 && ready) k1_idx++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input bit rnd);
    int base_hs, base_done;
    bit ok;
    base_hs = hs_cnt;
    base_done = done_cnt;
    ok = 0;
    start = 1;
    tick();
    start = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (done) begin ok = 1; break; end
    end
    check("scan_timeout", 32'(ok), 32'd1);
    check("scan_taps", 32'(hs_cnt - base_hs), 32'(NTAPS));
    ready = 1;
    repeat (3) tick();
    check("done_pulses", 32'(done_cnt - base_done), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  int lit_img[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

  initial begin
    int base, base_done;
    bit ok;
    rst = 1; start = 0; ready = 1;
    repeat (3) tick();
    rst = 0;
    tick();
    check("reset_outputs", 32'(pack(busy, done, valid, img, flt, wl, row, col)), 32'd0);

    check("model_size", 32'(e_img.size()), 32'd324);
    for (int k = 0; k < 9; k++) begin
      check("model_win0_img", 32'(e_img[k]), 32'(lit_img[k]));
      check("model_win0_flt", 32'(e_flt[k]), 32'(k));
      check("model_win0_last", 32'(e_wl[k]), 32'(k == 8));
    end
    check("model_tap10", 32'({e_img[9], e_col[9]}), 32'({32'd1, 32'd1}));
    check("model_tap55", 32'(e_img[54] * 256 + e_row[54] * 16 + e_col[54]), 32'(8 * 256 + 16));
    check("model_last", 32'(e_img[323] * 65536 + e_flt[323] * 256 + e_row[323] * 16 + e_col[323]),
          32'(63 * 65536 + 8 * 256 + 5 * 16 + 5));

    run_scan(0);
    run_scan(1);
    run_scan(1);

    // Abort after 100 accepted taps.
    base = hs_cnt;
    base_done = done_cnt;
    ok = 0;
    start = 1;
    tick();
    start = 0;
    ready = 1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      tick();
      if (hs_cnt - base == 100) begin ok = 1; break; end
    end
    check("abort_reach_100", 32'(ok), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    check("abort_outputs", 32'(pack(busy, done, valid, img, flt, wl, row, col)), 32'd0);
    repeat (3) tick();
    check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    run_scan(0);

    // start held high: back-to-back scans, one per IDLE visit.
    base_done = done_cnt;
    start = 1;
    ready = 1;
    repeat (700) tick();
    start = 0;
    check("held_start_dones", 32'(done_cnt - base_done), 32'd2);
    ok = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      tick();
      if (done) begin ok = 1; break; end
    end
    check("held_start_finish", 32'(ok), 32'd1);
    repeat (3) tick();
    check("held_start_total", 32'(done_cnt - base_done), 32'd3);
    check("held_start_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
